// File: rtl/prbs_sync_receiver_if.sv
// Received-word bus for the PRBS checker.
// master drives i_valid/i_rx_data; slave (the checker) samples them.
interface prbs_sync_receiver_if #(
    parameter int NB_DATA = 8
) ();
    logic               i_valid;
    logic [NB_DATA-1:0] i_rx_data;

    modport master (output i_valid, output i_rx_data);
    modport slave  (input  i_valid, input  i_rx_data);
endinterface

// File: rtl/prbs_sync_receiver.sv
// Receive-side checker for the 8-bit LFSR test link.
// Self-seeds from the stream, locks with hysteresis, counts word/bit errors.
// Ports: clk, i_rst (async, active-low), i_soft_reset, i_clr_count,
//        rx (i_valid, i_rx_data), o_lock, o_state, o_err_pulse,
//        o_word_errs, o_bit_errs (saturating).
module prbs_sync_receiver #(
    parameter int NB_DATA    = 8,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int NB_CNT     = 16
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_soft_reset,
    input  logic                i_clr_count,
    prbs_sync_receiver_if.slave rx,
    output logic                o_lock,
    output logic [1:0]          o_state,
    output logic                o_err_pulse,
    output logic [NB_CNT-1:0]   o_word_errs,
    output logic [NB_CNT-1:0]   o_bit_errs
);

    localparam logic [1:0] ST_SEARCH = 2'b00;
    localparam logic [1:0] ST_VERIFY = 2'b01;
    localparam logic [1:0] ST_LOCKED = 2'b10;
    localparam logic [1:0] ST_SLIP   = 2'b11;

    localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

    // Wide enough to hold counter + popcount without overflow.
    localparam int NB_SUM = NB_CNT + 4;
    localparam logic [NB_CNT-1:0] CNT_MAX = '1;

    logic [1:0]         state_q, state_d;
    logic [NB_DATA-1:0] ref_q, ref_d;
    logic [3:0]         mcnt_q, mcnt_d;
    logic [3:0]         miss_q, miss_d;
    logic [NB_CNT-1:0]  word_q, word_d;
    logic [NB_CNT-1:0]  bit_q, bit_d;
    logic               pulse_q, pulse_d;
    logic               lock_q, lock_d;

    logic [NB_DATA-1:0] rx_data;
    logic [NB_DATA-1:0] nxt_ref;
    logic [NB_DATA-1:0] diff;
    logic [3:0]         diff_ones;
    logic [NB_SUM-1:0]  bit_sum;
    logic [3:0]         mcnt_inc;
    logic [3:0]         miss_inc;
    logic               match;
    logic               err;

    assign rx_data  = rx.i_rx_data;
    assign nxt_ref  = {ref_q[NB_DATA-2:0],
                       ref_q[7] ^ ref_q[5] ^ ref_q[4] ^ ref_q[3]};
    assign match    = (rx_data == nxt_ref);
    assign diff     = rx_data ^ nxt_ref;
    assign mcnt_inc = mcnt_q + 4'd1;
    assign miss_inc = miss_q + 4'd1;
    assign bit_sum  = NB_SUM'(bit_q) + NB_SUM'(diff_ones);

    always_comb begin
        diff_ones = '0;
        for (int i = 0; i < NB_DATA; i++) begin
            diff_ones = diff_ones + 4'(diff[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        mcnt_d  = mcnt_q;
        miss_d  = miss_q;
        word_d  = word_q;
        bit_d   = bit_q;
        err     = 1'b0;

        if (rx.i_valid) begin
            unique case (state_q)
                ST_SEARCH: begin
                    // All-zero is the LFSR lockup word; never seed from it.
                    if (rx_data != '0) begin
                        ref_d   = rx_data;
                        mcnt_d  = '0;
                        state_d = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    ref_d = rx_data;
                    if (match) begin
                        mcnt_d = mcnt_inc;
                        if (mcnt_inc == LOCK_N) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        mcnt_d = '0;
                        if (rx_data == '0) begin
                            state_d = ST_SEARCH;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Free-running reference: a bad word costs one error only.
                    ref_d = nxt_ref;
                    if (!match) begin
                        err    = 1'b1;
                        miss_d = 4'd1;
                        state_d = (UNLOCK_N == 4'd1) ? ST_SEARCH : ST_SLIP;
                    end
                end
                ST_SLIP: begin
                    ref_d = nxt_ref;
                    if (match) begin
                        miss_d  = '0;
                        state_d = ST_LOCKED;
                    end else begin
                        err    = 1'b1;
                        miss_d = miss_inc;
                        if (miss_inc == UNLOCK_N) begin
                            state_d = ST_SEARCH;
                        end
                    end
                end
            endcase
        end

        pulse_d = err;

        // A clear in the same cycle as an error wins; the error is dropped.
        if (i_clr_count) begin
            word_d = '0;
            bit_d  = '0;
        end else if (err) begin
            if (word_q != CNT_MAX) begin
                word_d = word_q + NB_CNT'(1);
            end
            if (bit_sum > NB_SUM'(CNT_MAX)) begin
                bit_d = CNT_MAX;
            end else begin
                bit_d = bit_sum[NB_CNT-1:0];
            end
        end

        if (i_soft_reset) begin
            state_d = ST_SEARCH;
            ref_d   = '0;
            mcnt_d  = '0;
            miss_d  = '0;
            word_d  = '0;
            bit_d   = '0;
            pulse_d = 1'b0;
        end

        lock_d = (state_d == ST_LOCKED) || (state_d == ST_SLIP);
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_SEARCH;
            ref_q   <= '0;
            mcnt_q  <= '0;
            miss_q  <= '0;
            word_q  <= '0;
            bit_q   <= '0;
            pulse_q <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            mcnt_q  <= mcnt_d;
            miss_q  <= miss_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            pulse_q <= pulse_d;
            lock_q  <= lock_d;
        end
    end

    assign o_lock      = lock_q;
    assign o_state     = state_q;
    assign o_err_pulse = pulse_q;
    assign o_word_errs = word_q;
    assign o_bit_errs  = bit_q;

endmodule

// File: tb/tb_prbs_sync_receiver.sv
// Bench for prbs_sync_receiver: directed link scenarios plus random traffic,
// two instances (16-bit and 4-bit counters) checked against a stream model.
module tb_prbs_sync_receiver;

    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic i_rst;
    logic i_soft_reset;
    logic i_clr_count;

    prbs_sync_receiver_if #(.NB_DATA(8)) rx_if ();

    logic        lock_a, pulse_a;
    logic [1:0]  state_a;
    logic [15:0] werr_a, berr_a;
    logic        lock_b, pulse_b;
    logic [1:0]  state_b;
    logic [3:0]  werr_b, berr_b;

    prbs_sync_receiver #(.NB_DATA(8), .LOCK_CNT(LOCK_CNT),
                         .UNLOCK_CNT(UNLOCK_CNT), .NB_CNT(16)) dut_a (
        .clk(clk), .i_rst(i_rst), .i_soft_reset(i_soft_reset),
        .i_clr_count(i_clr_count), .rx(rx_if),
        .o_lock(lock_a), .o_state(state_a), .o_err_pulse(pulse_a),
        .o_word_errs(werr_a), .o_bit_errs(berr_a)
    );

    prbs_sync_receiver #(.NB_DATA(8), .LOCK_CNT(LOCK_CNT),
                         .UNLOCK_CNT(UNLOCK_CNT), .NB_CNT(4)) dut_b (
        .clk(clk), .i_rst(i_rst), .i_soft_reset(i_soft_reset),
        .i_clr_count(i_clr_count), .rx(rx_if),
        .o_lock(lock_b), .o_state(state_b), .o_err_pulse(pulse_b),
        .o_word_errs(werr_b), .o_bit_errs(berr_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] nxt(logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference model. Phases: 0 search, 1 verify, 2 locked, 3 slip.
    int         m_phase;
    logic [7:0] m_ref;
    int         m_good;
    int         m_bad;
    int         m_w16, m_b16, m_w4, m_b4;
    bit         m_pulse;

    task automatic model_reset();
        m_phase = 0; m_ref = 8'h00; m_good = 0; m_bad = 0;
        m_w16 = 0; m_b16 = 0; m_w4 = 0; m_b4 = 0; m_pulse = 0;
    endtask

    task automatic model_step();
        logic [7:0] w;
        logic [7:0] want;
        bit         bad;
        if (!i_rst || i_soft_reset) begin
            model_reset();
            return;
        end
        bad  = 0;
        w    = rx_if.i_rx_data;
        want = nxt(m_ref);
        if (rx_if.i_valid) begin
            if (m_phase == 0) begin
                if (w != 0) begin m_ref = w; m_good = 0; m_phase = 1; end
            end else if (m_phase == 1) begin
                m_ref = w;
                if (w == want) begin
                    m_good++;
                    if (m_good == LOCK_CNT) m_phase = 2;
                end else begin
                    m_good = 0;
                    if (w == 0) m_phase = 0;
                end
            end else begin
                m_ref = want;
                if (w == want) begin
                    m_bad = 0; m_phase = 2;
                end else begin
                    bad = 1;
                    m_bad = (m_phase == 2) ? 1 : m_bad + 1;
                    m_phase = (m_bad >= UNLOCK_CNT) ? 0 : 3;
                end
            end
        end
        m_pulse = bad;
        if (i_clr_count) begin
            m_w16 = 0; m_b16 = 0; m_w4 = 0; m_b4 = 0;
        end else if (bad) begin
            m_w16 = sat(m_w16 + 1, 65535);
            m_b16 = sat(m_b16 + $countones(w ^ want), 65535);
            m_w4  = sat(m_w4 + 1, 15);
            m_b4  = sat(m_b4 + $countones(w ^ want), 15);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("lock_a",  32'(lock_a),  32'(m_phase >= 2));
        check("state_a", 32'(state_a), 32'(m_phase));
        check("pulse_a", 32'(pulse_a), 32'(m_pulse));
        check("werr_a",  32'(werr_a),  32'(m_w16));
        check("berr_a",  32'(berr_a),  32'(m_b16));
        check("lock_b",  32'(lock_b),  32'(m_phase >= 2));
        check("state_b", 32'(state_b), 32'(m_phase));
        check("pulse_b", 32'(pulse_b), 32'(m_pulse));
        check("werr_b",  32'(werr_b),  32'(m_w4));
        check("berr_b",  32'(berr_b),  32'(m_b4));
    endtask

    logic [7:0] gen;

    task automatic send(bit v, logic [7:0] d);
        rx_if.i_valid   = v;
        rx_if.i_rx_data = d;
        tick();
    endtask

    task automatic clean();
        send(1'b1, gen);
        gen = nxt(gen);
    endtask

    task automatic corrupt(logic [7:0] mask);
        send(1'b1, gen ^ mask);
        gen = nxt(gen);
    endtask

    initial begin
        model_reset();
        i_rst = 1'b0; i_soft_reset = 1'b0; i_clr_count = 1'b0;
        rx_if.i_valid = 1'b0; rx_if.i_rx_data = 8'h00;

        // T1: reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            i_soft_reset = 1'($urandom);
            i_clr_count  = 1'($urandom);
            send(1'($urandom), 8'($urandom));
        end
        check("t1_state", 32'(state_a), 0);
        check("t1_words", 32'(werr_a), 0);
        check("t1_bits", 32'(berr_a), 0);
        i_rst = 1'b1; i_soft_reset = 1'b0; i_clr_count = 1'b0;

        // T2: acquire from seed 0x01
        gen = 8'h01;
        for (int i = 1; i <= 5; i++) begin
            clean();
            if (i == 4) check("t2_nolock4", 32'(lock_a), 0);
        end
        check("t2_lock5", 32'(lock_a), 1);
        check("t2_state", 32'(state_a), 2);
        check("t2_noerr", 32'(werr_a), 0);
        repeat (3) clean();

        // T3: single corrupted word
        corrupt(8'h01);
        check("t3_pulse", 32'(pulse_a), 1);
        check("t3_slip", 32'(state_a), 3);
        check("t3_lock", 32'(lock_a), 1);
        check("t3_words", 32'(werr_a), 1);
        check("t3_bits", 32'(berr_a), 1);
        clean();
        check("t3_relock", 32'(state_a), 2);
        check("t3_pulse0", 32'(pulse_a), 0);

        // T4: three corrupt words drop lock, five clean relock
        corrupt(8'h81);
        corrupt(8'h81);
        check("t4_lock2", 32'(lock_a), 1);
        corrupt(8'h81);
        check("t4_unlock", 32'(lock_a), 0);
        check("t4_bits", 32'(berr_a), 7);
        check("t4_words", 32'(werr_a), 4);
        repeat (4) clean();
        check("t4_nolock4", 32'(lock_a), 0);
        clean();
        check("t4_relock", 32'(lock_a), 1);

        // T5: gaps change nothing
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) send(1'b0, 8'($urandom));
            else clean();
        end
        check("t5_gaps", 32'(state_a), 2);
        check("t5_gapw", 32'(werr_a), 4);

        // Soft reset while locked
        i_soft_reset = 1'b1;
        clean();
        i_soft_reset = 1'b0;
        check("t5_srst", 32'(state_a), 0);
        check("t5_srstl", 32'(lock_a), 0);
        check("t5_srstw", 32'(werr_a), 0);
        repeat (5) send(1'b1, 8'h00);
        check("t5_zero", 32'(state_a), 0);
        repeat (5) clean();
        check("t5_reacq", 32'(lock_a), 1);

        // Clear coinciding with an error
        i_clr_count = 1'b1;
        corrupt(8'h0F);
        i_clr_count = 1'b0;
        check("clr_pulse", 32'(pulse_a), 1);
        check("clr_words", 32'(werr_a), 0);
        clean();

        // T6: saturation of the 4-bit counters
        for (int i = 0; i < 20; i++) begin
            corrupt(8'hFF);
            clean();
        end
        check("t6_wsat", 32'(werr_b), 15);
        check("t6_bsat", 32'(berr_b), 15);
        check("t6_w16", 32'(werr_a), 20);
        check("t6_b16", 32'(berr_a), 160);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            i_clr_count  = (r < 3);
            i_soft_reset = (r == 99);
            if (r < 20) begin
                send(1'b0, 8'($urandom));
            end else if (r < 30) begin
                corrupt(8'($urandom));
            end else if (r < 32) begin
                send(1'b1, 8'h00);
            end else begin
                clean();
            end
        end
        i_clr_count = 1'b0; i_soft_reset = 1'b0;
        send(1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
